// File: rtl/elevator_scan_controller.sv
// rtl/elevator_scan_controller.sv - SCAN elevator controller with latched calls and door dwell
// Optional emergency stop (estop input, HALT state) is built when ESTOP_EN is defined.
module elevator_scan_controller #(
    parameter int NUM_FLOORS  = 10,
    parameter int FLOOR_W     = 4,
    parameter int CNT_W       = 32,
    parameter int FLOOR_TICKS = 10000000,
    parameter int DOOR_TICKS  = 20000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ESTOP_EN
    input  logic                  estop,
`endif
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  idle
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOVE_UP   = 3'd1,
        S_MOVE_DOWN = 3'd2,
        S_DOOR      = 3'd3
`ifdef ESTOP_EN
        , S_HALT    = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0]   FLOOR_LAST  = CNT_W'(FLOOR_TICKS - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic                    dir_q, dir_d;

    logic [NUM_FLOORS-1:0]   clr_mask;
    logic [NUM_FLOORS-1:0]   set_mask;
    logic [FLOOR_W-1:0]      next_floor;
    logic [FLOOR_W-1:0]      eval_floor;
    logic                    call_ok;
    logic                    arrive_hit;
    logic                    above, below, ahead, behind;
    state_t                  scan_state;
    logic                    scan_dir;

    function automatic logic calls_above(input logic [FLOOR_W-1:0] f,
                                         input logic [NUM_FLOORS-1:0] p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) > f) r = r | p[i];
        return r;
    endfunction

    function automatic logic calls_below(input logic [FLOOR_W-1:0] f,
                                         input logic [NUM_FLOORS-1:0] p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) < f) r = r | p[i];
        return r;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) == f) r[i] = 1'b1;
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        timer_d    = timer_q + 1'b1;
        clr_mask   = '0;
        set_mask   = '0;
        call_ok    = call_valid && ({1'b0, call_floor} < FLOOR_LIMIT);
        next_floor = (state_q == S_MOVE_DOWN) ? floor_q - 1'b1 : floor_q + 1'b1;
        arrive_hit = (|(pending_q & floor_bit(next_floor))) ||
                     (call_ok && call_floor == next_floor);

        // One SCAN evaluation per cycle: at the arriving floor while moving, else here.
        eval_floor = (state_q == S_MOVE_UP || state_q == S_MOVE_DOWN) ? next_floor : floor_q;
        above      = calls_above(eval_floor, pending_q);
        below      = calls_below(eval_floor, pending_q);
        ahead      = dir_q ? above : below;
        behind     = dir_q ? below : above;
        scan_state = S_IDLE;
        scan_dir   = dir_q;
        if (ahead) begin
            scan_state = dir_q ? S_MOVE_UP : S_MOVE_DOWN;
        end else if (behind) begin
            scan_state = dir_q ? S_MOVE_DOWN : S_MOVE_UP;
            scan_dir   = ~dir_q;
        end

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (|(pending_q & floor_bit(floor_q))) begin
                    state_d  = S_DOOR;
                    clr_mask = floor_bit(floor_q);
                end else begin
                    state_d = scan_state;
                    dir_d   = scan_dir;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (timer_q == FLOOR_LAST) begin
                    floor_d = next_floor;
                    timer_d = '0;
                    if (arrive_hit) begin
                        state_d  = S_DOOR;
                        clr_mask = floor_bit(next_floor);
                    end else begin
                        state_d = scan_state;
                        dir_d   = scan_dir;
                    end
                end
            end
            S_DOOR: begin
                if (call_ok && call_floor == floor_q) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = scan_state;
                    dir_d   = scan_dir;
                    timer_d = '0;
                end
            end
`ifdef ESTOP_EN
            S_HALT: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
`endif
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

`ifdef ESTOP_EN
        if (estop) begin
            state_d  = S_HALT;
            floor_d  = floor_q;
            dir_d    = dir_q;
            timer_d  = timer_q;
            clr_mask = '0;
        end
`endif

        // A call for the floor whose door is (or stays) open is absorbed, not latched.
        for (int i = 0; i < NUM_FLOORS; i++)
            if (call_ok && call_floor == FLOOR_W'(i) &&
                !(state_d == S_DOOR && floor_d == FLOOR_W'(i)))
                set_mask[i] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            dir_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
        end
    end

    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign moving        = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    assign dir_up        = dir_q;
    assign door_open     = (state_q == S_DOOR);
    assign idle          = (state_q == S_IDLE);

endmodule
